mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one mem_ctrl cache-line port between num_req requesters (rasterizer, texture fetch, display scan-out, shader LSU).
- Round-robin arbitration; one line-sized command in flight at a time.
- Sequences the mem_ctrl handshake (enabled, data_ready, r_valid/w_valid pulses, r_valid_o return) and routes the read line back to the granted requester.
- Sits between the requester fabric and mem_ctrl.

Parameters:
- num_req, 4, number of requesters; power of two, ≥2.
- addr_width, 20, cache-line address width; must match mem_ctrl.
- line_width, 128, cache-line width in bits; must match mem_ctrl.
- rd_timeout, 4096, cycles to wait for mem read return before flagging an error; ≥16.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  num_req  per-requester request valid; held until accepted.
- req_we_i  in  num_req  1 = write line, 0 = read line.
- req_addr_i  in  num_req*addr_width  packed per-requester line addresses.
- req_wdata_i  in  num_req*line_width  packed per-requester write lines.
- req_ready_o  out  num_req  one-hot, one-cycle accept pulse.
- rsp_valid_o  out  num_req  one-hot, one-cycle read-data-valid pulse.
- rsp_data_o  out  line_width  read line, valid with rsp_valid_o.
- busy_o  out  1  a command is in flight.
- timeout_o  out  1  sticky read-timeout error.
- mem_enabled_i  in  1  mem_ctrl enabled_o.
- mem_ready_i  in  1  mem_ctrl data_ready_o.
- mem_addr_o  out  addr_width  to mem_ctrl addr_i.
- mem_r_valid_o  out  1  to mem_ctrl r_valid_i, one-cycle pulse.
- mem_w_valid_o  out  1  to mem_ctrl w_valid_i, one-cycle pulse.
- mem_write_o  out  line_width  to mem_ctrl write_i.
- mem_r_valid_i  in  1  mem_ctrl r_valid_o.
- mem_read_i  in  line_width  mem_ctrl read_o.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; rr_ptr=0; all outputs 0; timeout_o=0; counters 0.
- State IDLE:
  - When mem_enabled_i & mem_ready_i & |req_valid_i, grant the first valid requester at or after rr_ptr (wrap modulo num_req).
  - Same cycle: pulse req_ready_o[g]; drive mem_addr_o, mem_write_o; pulse mem_r_valid_o or mem_w_valid_o per req_we_i[g]. All mem_* outputs are registered and appear the cycle after the grant decision, so the issue cycle is grant+1.
  - Latch g and the command type; rr_ptr <= g+1 (wraps).
  - No grant while mem_enabled_i=0, e.g. during SDRAM init.
- State ISSUE (1 cycle, mem pulse on wire) → WAIT_RD or WAIT_WR.
- State WAIT_RD:
  - On mem_r_valid_i: rsp_data_o <= mem_read_i; rsp_valid_o[g] pulses next cycle; → DRAIN.
  - A cache hit may return 1–2 cycles after issue; a miss may take hundreds of cycles. Both are legal.
- State WAIT_WR: complete on the first cycle with mem_ready_i=1 → DRAIN. A write produces no rsp_valid_o.
- State DRAIN (1 cycle): guards mem_ctrl's issued flag clearing → IDLE.
- busy_o = state != IDLE.
- mem_addr_o and mem_write_o hold their values until the next grant.
- Read timeout: a counter runs in WAIT_RD. When it reaches rd_timeout:
  - timeout_o <= 1 (sticky until reset);
  - rsp_valid_o[g] pulses with rsp_data_o = 0;
  - → DRAIN.
- Stray mem_r_valid_i outside WAIT_RD is ignored.
- Simultaneous new req_valid_i while busy: held, not accepted; round-robin guarantees service within num_req grants.
- Requester deasserting req_valid_i before accept: legal, no effect.
- Reset mid-command: arbiter returns to IDLE. mem_ctrl has no reset, so the system resets both only together with SDRAM re-init.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ISSUE, WAIT_RD, WAIT_WR, DRAIN); timeout counter width function clog2(rd_timeout+1).
- Sub-module rr_picker: combinational-plus-pointer round-robin selector. Inputs req vector and rr_ptr; outputs grant index and any-valid. Reusable for the display/texture arbiters.

Test Plan:
- Single read: req 1 reads addr 0x00042 after init; mem returns line 0xDEAD..BEEF 3 cycles after issue → req_ready_o=0b0010 once, mem_r_valid_o single pulse with addr 0x00042, rsp_valid_o=0b0010 with matching data, busy_o low after DRAIN.
- Round-robin fairness: all 4 requesters hold reads continuously with rr_ptr=0 → grants in order 0,1,2,3,0; no requester granted twice before the others.
- Write completion: req 2 writes 0x1234 with mem_ready_i held low 10 cycles after issue → no rsp_valid_o; next grant occurs only after mem_ready_i=1 plus the DRAIN cycle.
- Init gating: req_valid_i=0b1111 with mem_enabled_i=0 for 200 cycles → no req_ready_o and no mem pulses; first grant goes to req 0 on the cycle after enable.
- Timeout: read issued, mem_r_valid_i never asserted, rd_timeout=16 → rsp_valid_o pulse with rsp_data_o=0 after 16 WAIT_RD cycles; timeout_o stays 1; a later stray mem_r_valid_i is ignored.
- Async reset in WAIT_RD: rst_i pulsed mid-cycle → all outputs 0 immediately; rr_ptr=0; no rsp_valid_o after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_ctrl line-port arbiter.
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_RD,
      WAIT_WR,
      DRAIN
   } state_t;

   // Counter must be able to hold rd_timeout itself.
   function automatic int tmo_cnt_w(input int rd_timeout);
      return $clog2(rd_timeout + 1);
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: first asserted request at or after rr_ptr, wrapping.
module rr_picker #(
   parameter int num_req = 4
) (
   input  logic [num_req-1:0]         req,
   input  logic [$clog2(num_req)-1:0] rr_ptr,
   output logic [$clog2(num_req)-1:0] grant,
   output logic                       any
);

   localparam int IW = $clog2(num_req);

   logic [IW-1:0] idx;

   // Walk from the farthest offset down so the nearest valid one wins.
   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = '0;
      for (int i = num_req - 1; i >= 0; i--) begin
         idx = rr_ptr + IW'(i);
         if (req[idx]) begin
            grant = idx;
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_ctrl cache-line port between num_req requesters,
// one command in flight, round-robin grant, read line routed back.
import mem_arb_pkg::*;

module mem_arbiter #(
   parameter int num_req    = 4,
   parameter int addr_width = 20,
   parameter int line_width = 128,
   parameter int rd_timeout = 4096
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [num_req-1:0]               req_valid_i,
   input  logic [num_req-1:0]               req_we_i,
   input  logic [num_req*addr_width-1:0]    req_addr_i,
   input  logic [num_req*line_width-1:0]    req_wdata_i,
   output logic [num_req-1:0]               req_ready_o,
   output logic [num_req-1:0]               rsp_valid_o,
   output logic [line_width-1:0]            rsp_data_o,
   output logic                             busy_o,
   output logic                             timeout_o,
   input  logic                             mem_enabled_i,
   input  logic                             mem_ready_i,
   output logic [addr_width-1:0]            mem_addr_o,
   output logic                             mem_r_valid_o,
   output logic                             mem_w_valid_o,
   output logic [line_width-1:0]            mem_write_o,
   input  logic                             mem_r_valid_i,
   input  logic [line_width-1:0]            mem_read_i
);

   localparam int IW = $clog2(num_req);
   localparam int CW = tmo_cnt_w(rd_timeout);
   localparam logic [num_req-1:0] ONE = {{(num_req-1){1'b0}}, 1'b1};

   state_t        state, state_nxt;
   logic [IW-1:0] rr_ptr, gnt, sel;
   logic          any_vld, is_wr;
   logic [CW-1:0] tmo_cnt;
   logic          grant_fire, rd_done, rd_to;

   rr_picker #(.num_req(num_req)) u_pick (
      .req    (req_valid_i),
      .rr_ptr (rr_ptr),
      .grant  (sel),
      .any    (any_vld)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      grant_fire = 1'b0;
      rd_done    = 1'b0;
      rd_to      = 1'b0;
      case (state)
         IDLE:
            if (mem_enabled_i && mem_ready_i && any_vld) begin
               grant_fire = 1'b1;
               state_nxt  = ISSUE;
            end
         ISSUE:   state_nxt = is_wr ? WAIT_WR : WAIT_RD;
         // Real data wins over the timeout if both land on the last cycle.
         WAIT_RD:
            if (mem_r_valid_i) begin
               rd_done   = 1'b1;
               state_nxt = DRAIN;
            end else if (tmo_cnt == CW'(rd_timeout - 1)) begin
               rd_to     = 1'b1;
               state_nxt = DRAIN;
            end
         WAIT_WR: if (mem_ready_i) state_nxt = DRAIN;
         DRAIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr        <= '0;
         gnt           <= '0;
         is_wr         <= 1'b0;
         tmo_cnt       <= '0;
         req_ready_o   <= '0;
         rsp_valid_o   <= '0;
         rsp_data_o    <= '0;
         timeout_o     <= 1'b0;
         mem_addr_o    <= '0;
         mem_write_o   <= '0;
         mem_r_valid_o <= 1'b0;
         mem_w_valid_o <= 1'b0;
      end else begin
         req_ready_o   <= '0;
         rsp_valid_o   <= '0;
         mem_r_valid_o <= 1'b0;
         mem_w_valid_o <= 1'b0;
         tmo_cnt       <= (state == WAIT_RD) ? tmo_cnt + CW'(1) : '0;
         if (grant_fire) begin
            req_ready_o   <= ONE << sel;
            mem_addr_o    <= req_addr_i[int'(sel)*addr_width +: addr_width];
            mem_write_o   <= req_wdata_i[int'(sel)*line_width +: line_width];
            mem_r_valid_o <= ~req_we_i[sel];
            mem_w_valid_o <= req_we_i[sel];
            gnt           <= sel;
            is_wr         <= req_we_i[sel];
            rr_ptr        <= sel + IW'(1);
         end
         if (rd_done) begin
            rsp_data_o  <= mem_read_i;
            rsp_valid_o <= ONE << gnt;
         end
         if (rd_to) begin
            rsp_data_o  <= '0;
            rsp_valid_o <= ONE << gnt;
            timeout_o   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-schedule model.
module tb_mem_arbiter;

   localparam int NR   = 4;
   localparam int AW   = 20;
   localparam int LW   = 128;
   localparam int TMO  = 16;
   localparam int NCYC = 2900;
   localparam int MAXC = 3000;
   localparam int BIG  = 1000000;

   logic              clk_i, rst_i;
   logic [NR-1:0]     req_valid_i, req_we_i;
   logic [NR*AW-1:0]  req_addr_i;
   logic [NR*LW-1:0]  req_wdata_i;
   logic [NR-1:0]     req_ready_o, rsp_valid_o;
   logic [LW-1:0]     rsp_data_o;
   logic              busy_o, timeout_o;
   logic              mem_enabled_i, mem_ready_i;
   logic [AW-1:0]     mem_addr_o;
   logic              mem_r_valid_o, mem_w_valid_o;
   logic [LW-1:0]     mem_write_o;
   logic              mem_r_valid_i;
   logic [LW-1:0]     mem_read_i;

   mem_arbiter #(.num_req(NR), .addr_width(AW), .line_width(LW), .rd_timeout(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
      .busy_o(busy_o), .timeout_o(timeout_o),
      .mem_enabled_i(mem_enabled_i), .mem_ready_i(mem_ready_i),
      .mem_addr_o(mem_addr_o), .mem_r_valid_o(mem_r_valid_o),
      .mem_w_valid_o(mem_w_valid_o), .mem_write_o(mem_write_o),
      .mem_r_valid_i(mem_r_valid_i), .mem_read_i(mem_read_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // Expected events per cycle, filled in when the model makes a grant.
   bit [NR-1:0] exp_rdy [MAXC];
   bit [NR-1:0] exp_rsp [MAXC];
   bit [LW-1:0] exp_data[MAXC];
   bit          exp_busy[MAXC];
   bit          exp_mr  [MAXC];
   bit          exp_mw  [MAXC];
   bit          exp_aset[MAXC];
   bit [AW-1:0] exp_a   [MAXC];
   bit [LW-1:0] exp_w   [MAXC];
   int          gnt_at  [MAXC];
   // Bench-side memory behaviour schedule.
   bit          in_wrd  [MAXC];
   bit          drv_rv  [MAXC];
   bit [LW-1:0] drv_rd  [MAXC];
   int          rdy_frc [MAXC];   // 0 free, 1 force low, 2 force high

   bit          pend_v [NR];
   bit          pend_we[NR];
   bit [AW-1:0] pend_a [NR];
   bit [LW-1:0] pend_wd[NR];

   int          m_rr, free_cyc, tmo_from, force_lat, mode;
   bit [AW-1:0] h_addr;
   bit [LW-1:0] h_wd;
   bit          rel_rst, did_rst;

   function automatic bit [LW-1:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic new_req(input int i, input bit we);
      pend_v[i]  = 1'b1;
      pend_we[i] = we;
      pend_a[i]  = AW'($urandom);
      pend_wd[i] = rnd_line();
   endtask

   initial begin
      bit          en, rdy, any;
      int          g, L, H, rsp_c, fr;
      bit [LW-1:0] d;
      rst_i = 1'b1;
      req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0;
      mem_enabled_i = 1'b0; mem_ready_i = 1'b0; mem_r_valid_i = 1'b0; mem_read_i = '0;
      m_rr = 0; free_cyc = 0; tmo_from = BIG; force_lat = -1;
      h_addr = '0; h_wd = '0; rel_rst = 1'b0; did_rst = 1'b0;
      for (int i = 0; i < NR; i++) new_req(i, 1'b0);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      for (int k = 0; k < NCYC; k++) begin
         if (k > 0) @(negedge clk_i);
         cyc = k;
         if (rel_rst) begin rst_i = 1'b0; rel_rst = 1'b0; end
         mode = (k < 300) ? 0 : (k < 2800) ? 1 : 2;

         // Compare everything the DUT shows this cycle.
         if (exp_aset[k]) begin h_addr = exp_a[k]; h_wd = exp_w[k]; end
         chk("req_ready", LW'(req_ready_o), LW'(exp_rdy[k]));
         chk("rsp_valid", LW'(rsp_valid_o), LW'(exp_rsp[k]));
         if (exp_rsp[k] != '0) chk("rsp_data", rsp_data_o, exp_data[k]);
         chk("busy", LW'(busy_o), LW'(exp_busy[k]));
         chk("mem_r_valid", LW'(mem_r_valid_o), LW'(exp_mr[k]));
         chk("mem_w_valid", LW'(mem_w_valid_o), LW'(exp_mw[k]));
         chk("mem_addr", LW'(mem_addr_o), LW'(h_addr));
         chk("mem_write", mem_write_o, h_wd);
         chk("timeout", LW'(timeout_o), LW'(k >= tmo_from));

         // Requesters: retire accepted commands, raise/drop others.
         if (exp_rdy[k] != '0) begin
            pend_v[gnt_at[k]] = 1'b0;
            if (mode == 0) new_req(gnt_at[k], 1'b0);
         end
         if (k == 2800) begin
            for (int i = 0; i < NR; i++) pend_v[i] = 1'b0;
            pend_v[1] = 1'b1; pend_we[1] = 1'b0; pend_a[1] = 20'h00042;
            pend_wd[1] = rnd_line();
            force_lat = 3;
         end
         if (mode == 1) begin
            for (int i = 0; i < NR; i++) begin
               if (!pend_v[i] && $urandom_range(0, 99) < 30) new_req(i, 1'($urandom));
               else if (pend_v[i] && $urandom_range(0, 99) < 3) pend_v[i] = 1'b0;
            end
         end
         for (int i = 0; i < NR; i++) begin
            req_valid_i[i] = pend_v[i];
            req_we_i[i]    = pend_we[i];
            req_addr_i[i*AW +: AW]  = pend_a[i];
            req_wdata_i[i*LW +: LW] = pend_wd[i];
         end

         // Memory side.
         en  = (mode == 0) ? (k >= 200) : (mode == 1) ? ($urandom_range(0, 9) != 0) : 1'b1;
         rdy = (mode == 1) ? ($urandom_range(0, 99) < 85) : 1'b1;
         if (rdy_frc[k] == 1) rdy = 1'b0;
         if (rdy_frc[k] == 2) rdy = 1'b1;
         mem_enabled_i = en;
         mem_ready_i   = rdy;
         if (drv_rv[k]) begin
            mem_r_valid_i = 1'b1; mem_read_i = drv_rd[k];
         end else begin
            mem_r_valid_i = (mode == 1) && !in_wrd[k] && ($urandom_range(0, 99) < 5);
            mem_read_i    = rnd_line();
         end

         // Model grant decision for this cycle.
         any = 1'b0; g = 0;
         for (int j = NR - 1; j >= 0; j--)
            if (pend_v[(m_rr + j) % NR]) begin g = (m_rr + j) % NR; any = 1'b1; end
         if (k >= free_cyc && en && rdy && any) begin
            exp_rdy[k+1]  = NR'(1) << g;
            gnt_at[k+1]   = g;
            exp_mr[k+1]   = !pend_we[g];
            exp_mw[k+1]   = pend_we[g];
            exp_aset[k+1] = 1'b1;
            exp_a[k+1]    = pend_a[g];
            exp_w[k+1]    = pend_wd[g];
            if (!pend_we[g]) begin
               d = rnd_line();
               if (force_lat >= 0) begin
                  L = force_lat; force_lat = -1;
                  d = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
               end else begin
                  H = $urandom_range(0, 9);
                  L = (H < 3) ? $urandom_range(1, 3) : (H < 8) ? $urandom_range(4, TMO) : BIG;
               end
               if (L <= TMO) begin
                  drv_rv[k+1+L] = 1'b1; drv_rd[k+1+L] = d;
                  rsp_c = k + 2 + L;
                  exp_data[rsp_c] = d;
               end else begin
                  rsp_c = k + 2 + TMO;
                  exp_data[rsp_c] = '0;
                  if (tmo_from > rsp_c) tmo_from = rsp_c;
               end
               exp_rsp[rsp_c] = NR'(1) << g;
               for (int j = k + 2; j < rsp_c; j++) in_wrd[j] = 1'b1;
               fr = rsp_c + 1;
            end else begin
               H = $urandom_range(0, 10);
               for (int j = k + 2; j < k + 2 + H; j++) rdy_frc[j] = 1;
               rdy_frc[k+2+H] = 2;
               fr = k + 4 + H;
            end
            for (int j = k + 1; j < fr; j++) exp_busy[j] = 1'b1;
            free_cyc = fr;
            m_rr = (g + 1) % NR;
         end

         // Asynchronous reset landing mid-cycle while a read is outstanding.
         if (mode == 1 && !did_rst && k >= 2000 && in_wrd[k]) begin
            did_rst = 1'b1;
            #2 rst_i = 1'b1;
            #1;
            chk("rst_ready", LW'(req_ready_o), '0);
            chk("rst_rsp_valid", LW'(rsp_valid_o), '0);
            chk("rst_rsp_data", rsp_data_o, '0);
            chk("rst_busy", LW'(busy_o), '0);
            chk("rst_timeout", LW'(timeout_o), '0);
            chk("rst_mem_pulse", LW'({mem_r_valid_o, mem_w_valid_o}), '0);
            chk("rst_mem_addr", LW'(mem_addr_o), '0);
            chk("rst_mem_write", mem_write_o, '0);
            for (int j = k + 1; j < k + 40; j++) begin
               exp_rdy[j] = '0; exp_rsp[j] = '0; exp_busy[j] = 1'b0;
               exp_mr[j] = 1'b0; exp_mw[j] = 1'b0; exp_aset[j] = 1'b0;
               in_wrd[j] = 1'b0; drv_rv[j] = 1'b0; rdy_frc[j] = 0;
            end
            free_cyc = k + 1; m_rr = 0; tmo_from = BIG;
            h_addr = '0; h_wd = '0;
            rel_rst = 1'b1;
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
